// File: rtl/surf_dna_reader.sv
// Wishbone-controlled sequencer that reads the 96-bit device DNA into three read-only words.
// Optional feature: define SURF_DNA_AUTOLOAD_EN to start one read automatically after reset.
module surf_dna_reader #(
  parameter int DNA_BITS  = 96,
  parameter int SHIFT_DIV = 1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  output logic        dna_din_o,
  output logic        dna_read_o,
  output logic        dna_shift_o,
  input  logic        dna_dout_i,
  output logic        dna_valid_o
);

  if (SHIFT_DIV < 1 || SHIFT_DIV > 16 || DNA_BITS != 96) begin : g_bad_param
    $error("surf_dna_reader: SHIFT_DIV must be 1..16 and DNA_BITS must be 96");
  end

  localparam logic [3:0] DIV_LAST = 4'(SHIFT_DIV - 1);
  localparam logic [6:0] BIT_LAST = 7'(DNA_BITS - 1);
  localparam logic       FAST     = (SHIFT_DIV == 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    SHIFT  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t       state;
  logic [6:0]   bit_idx;
  logic [3:0]   div_cnt;
  logic [95:0]  dna;
  logic         busy;
  logic         valid;
  logic         bus_req;
  logic         start_wr;
  logic         auto_start;
  logic         start;
  logic         unused;

  // Handshake: a request is (cyc & stb) while ack is low; ack answers it one cycle
  // later for exactly one cycle, and writes take effect on that same ack-rising edge.
  assign bus_req  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign start_wr = bus_req & wb_we_i & (wb_adr_i[3:2] == 2'd0) & wb_sel_i[0] & wb_dat_i[0];

`ifdef SURF_DNA_AUTOLOAD_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) auto_start <= 1'b1;
    else          auto_start <= 1'b0;
  end
`else
  assign auto_start = 1'b0;
`endif

  assign start = start_wr | auto_start;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) wb_ack_o <= 1'b0;
    else          wb_ack_o <= wb_cyc_i & wb_stb_i & ~wb_ack_o;
  end

  always_comb begin
    wb_dat_o = 32'd0;
    case (wb_adr_i[3:2])
      2'd0:    wb_dat_o = {29'd0, valid, busy, 1'b0};
      2'd1:    wb_dat_o = dna[31:0];
      2'd2:    wb_dat_o = dna[63:32];
      default: wb_dat_o = dna[95:64];
    endcase
  end

  // SHIFT is registered one cycle ahead so it is high during the cycle whose closing
  // edge both samples DOUT and advances the DNA port to the next bit.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      bit_idx     <= 7'd0;
      div_cnt     <= 4'd0;
      dna         <= 96'd0;
      busy        <= 1'b0;
      valid       <= 1'b0;
      dna_read_o  <= 1'b0;
      dna_shift_o <= 1'b0;
    end else begin
      dna_read_o  <= 1'b0;
      dna_shift_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dna        <= 96'd0;
            valid      <= 1'b0;
            busy       <= 1'b1;
            dna_read_o <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: state <= SETTLE;
        SETTLE: begin
          bit_idx     <= 7'd0;
          div_cnt     <= 4'd0;
          dna_shift_o <= FAST;
          state       <= SHIFT;
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            dna[bit_idx] <= dna_dout_i;
            div_cnt      <= 4'd0;
            if (bit_idx == BIT_LAST) begin
              state <= DONE;
            end else begin
              bit_idx     <= bit_idx + 7'd1;
              dna_shift_o <= FAST && ((bit_idx + 7'd1) != BIT_LAST);
            end
          end else begin
            div_cnt     <= div_cnt + 4'd1;
            dna_shift_o <= ((div_cnt + 4'd1) == DIV_LAST) && (bit_idx != BIT_LAST);
          end
        end
        DONE: begin
          valid <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dna_valid_o = valid;
  assign wb_err_o    = 1'b0;
  assign wb_rty_o    = 1'b0;
  assign dna_din_o   = 1'b0;
  assign unused      = ^{wb_dat_i[31:1], wb_sel_i[3:1], wb_adr_i[1:0]};

endmodule

// File: doc/surf_dna_reader.md
Name: surf_dna_reader

Overview:
- Wishbone-controlled sequencer for the device DNA port (DNA_PORTE2, instantiated by the parent and wired to the dna_* ports).
- On command it issues the READ strobe, then clocks out all 96 DNA bits.
- The bits are captured into three 32-bit read-only registers, so software gets the full DNA in three reads instead of bit-banging 96 shifts.
- Sits in the ID/control wishbone space next to the ID and clock-monitor registers.

Parameters:
DNA_BITS, 96, number of bits shifted out of the DNA port; fixed at 96 for the 3-word register map.
SHIFT_DIV, 1, wb_clk_i cycles per DNA bit (1..16); slows SHIFT/sampling for fast wishbone clocks.

Ports:
wb_clk_i  in  1  wishbone/system clock; sole clock of the block
wb_rst_i  in  1  asynchronous, active-high reset
wb_cyc_i  in  1  wishbone cycle
wb_stb_i  in  1  wishbone strobe
wb_we_i  in  1  write enable
wb_adr_i  in  4  byte address; [3:2] selects the register
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte selects
wb_dat_o  out  32  read data
wb_ack_o  out  1  acknowledge
wb_err_o  out  1  tied 0
wb_rty_o  out  1  tied 0
dna_din_o  out  1  to DNA_PORTE2 DIN; tied 0
dna_read_o  out  1  to DNA_PORTE2 READ
dna_shift_o  out  1  to DNA_PORTE2 SHIFT
dna_dout_i  in  1  from DNA_PORTE2 DOUT
dna_valid_o  out  1  high when the DNA registers hold a complete read

Behaviour:
- Clock and reset: one clock, wb_clk_i. wb_rst_i is asynchronous and active-high.
- Reset values: all outputs 0, FSM in IDLE, DNA registers 0, valid 0.
- Register map (wb_adr_i[3:2]):
  - 0 CTRL/STAT: write bit0=1 with wb_sel_i[0] = START. Read: bit0 0, bit1 busy, bit2 valid, bits[31:3] 0.
  - 1 DNA[31:0]; 2 DNA[63:32]; 3 DNA[95:64]. All read-only; writes are acked and ignored.
- Wishbone handshake:
  - wb_ack_o <= cyc&stb&!wb_ack_o. One wait state; single-cycle ack; never asserted on consecutive cycles.
  - wb_dat_o is combinational from wb_adr_i[3:2].
  - A write takes effect on the edge where wb_ack_o=1.
- DNA port model assumed by the design:
  - READ high on one edge loads the shift register; DOUT then shows bit 0.
  - Each edge with SHIFT high advances DOUT to the next bit (LSB first).
- FSM:
  - IDLE: START accepted -> clear DNA registers and valid, busy=1, go to LOAD.
  - LOAD: dna_read_o=1 for exactly 1 cycle -> SETTLE.
  - SETTLE: 1 cycle, all strobes low -> SHIFT with bit counter=0 and divider=0.
  - SHIFT:
    - Divider counts 0..SHIFT_DIV-1.
    - On divider=SHIFT_DIV-1: capture dna_dout_i into DNA[bit]. If bit<95, assert dna_shift_o for that cycle and increment bit; if bit==95, no shift and go to DONE.
    - dna_shift_o is a single-cycle pulse, registered.
  - DONE: valid=1, busy=0 -> IDLE in the same transition (1 cycle).
- Latency: valid rises 2+96*SHIFT_DIV+1 cycles after the START-accept edge (99 for SHIFT_DIV=1).
- dna_valid_o mirrors STAT bit2.
- Boundary conditions:
  - START while busy: ignored; the running read is not restarted.
  - START with valid=1: starts a new read; valid drops the next cycle.
  - Reads of DNA registers while busy return partially filled values; software must gate on valid.
  - Reset mid-read: immediate return to IDLE, strobes low, registers and valid cleared.
  - SHIFT_DIV outside 1..16: elaboration error.

Optional Feature:
- Macro SURF_DNA_AUTOLOAD_EN.
- Defined: the first clock after reset deassertion issues an internal START, so valid rises with no software access (99 cycles at SHIFT_DIV=1). Later STARTs behave normally.
- Undefined: the FSM stays in IDLE until a wishbone START.

Test Plan:
- Reset, read all four registers -> CTRL=0x0, DNA words 0x00000000, ack exactly 1 cycle after stb each time.
- DNA model loaded with 96'h0123456789ABCDEFDEADBEEF, SHIFT_DIV=1, write 0x1 to 0x0 -> 1 READ pulse, 95 SHIFT pulses, valid after 99 cycles. Then 0x4=DEADBEEF, 0x8=89ABCDEF, 0xC=01234567, CTRL=0x4.
- SHIFT_DIV=4, same DNA value -> SHIFT pulses spaced 4 cycles, valid after 387 cycles, identical words.
- Second START 20 cycles into a read -> READ not reasserted, completion time unchanged. START with wb_sel_i=4'b1110 -> ignored.
- Assert wb_rst_i asynchronously mid-SHIFT (bit 40) -> dna_shift_o/dna_read_o low immediately, CTRL=0, DNA words 0; a fresh START then yields correct data.
- With SURF_DNA_AUTOLOAD_EN, release reset and issue no bus traffic -> dna_valid_o high 99 cycles later with the correct DNA.
